// File: rtl/camera_capture_v3.sv
// camera_capture_v3
// Bayer capture engine. Samples a synchronised sensor stream, folds every
// 2x2 Bayer cell (G1,B on even lines / R,G2 on odd lines) into one packed
// RGB word, queues the words in a small FIFO and writes them to DDR through
// a pause-handshaked memory port. Per-channel sums are kept for the AGC.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   grab_enable         level; rising edge starts a frame, low aborts
//   grab_done           frame written; held until grab_enable falls
//   base_addr           DDR word address of pixel 0, sampled at grab start
//   cam_href/cam_vsync  line / frame valid, already synchronous to clk
//   cam_data            sensor sample, valid when href and vsync are high
//   mem_addr/mem_data   write address and {B, 8'h00, G, R} data word
//   mem_wren            one-cycle write strobe
//   mem_pause           memory controller busy
//   red/green/blue_sum  saturating sums of captured R, G1 and B values
//   words_written       DDR writes issued this frame
//   overflow            sticky, a pixel was dropped on FIFO full
module camera_capture_v3 #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 20,
    parameter int OUT_WIDTH  = 320,
    parameter int OUT_HEIGHT = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int SUM_WIDTH  = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  grab_enable,
    output logic                  grab_done,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  cam_href,
    input  logic                  cam_vsync,
    input  logic [DATA_WIDTH-1:0] cam_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  mem_wren,
    input  logic                  mem_pause,
    output logic [SUM_WIDTH-1:0]  red_sum,
    output logic [SUM_WIDTH-1:0]  green_sum,
    output logic [SUM_WIDTH-1:0]  blue_sum,
    output logic [ADDR_WIDTH-1:0] words_written,
    output logic                  overflow
);

    localparam int COL_W = $clog2(2 * OUT_WIDTH + 1);
    localparam int ROW_W = $clog2(2 * OUT_HEIGHT + 1);
    localparam int IDX_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COL_W-1:0] COL_LIM = COL_W'(2 * OUT_WIDTH);
    localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(2 * OUT_HEIGHT);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic                  r_grab_q, r_vsync_q, r_href_q;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [7:0]            r_line_g [OUT_WIDTH];
    logic [7:0]            r_line_b [OUT_WIDTH];
    logic [31:0]           r_fifo   [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_mem_addr, r_words;
    logic [31:0]           r_mem_data;
    logic                  r_mem_wren, r_overflow;
    logic [SUM_WIDTH-1:0]  r_red, r_green, r_blue;

    logic [7:0]       w_chan;
    logic [IDX_W-1:0] w_idx;
    logic             w_grab_rise, w_vsync_rise, w_vsync_fall, w_href_fall;
    logic             w_sample, w_push, w_pop, w_full, w_push_ok, w_drop;
    logic             w_write_side, w_pop_ok, w_start;
    logic             w_unused;

    // Saturating accumulate: a carry out of the top bit pins the sum at all-ones.
    function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                      input logic [7:0] b);
        logic [SUM_WIDTH:0] s;
        s = {1'b0, a} + {{(SUM_WIDTH - 7){1'b0}}, b};
        return s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
    endfunction

    assign w_chan       = cam_data[DATA_WIDTH-1 -: 8];
    assign w_unused     = ^cam_data[DATA_WIDTH-9:0];
    assign w_idx        = r_col[IDX_W:1];
    assign w_grab_rise  = grab_enable & ~r_grab_q;
    assign w_vsync_rise = cam_vsync & ~r_vsync_q;
    assign w_vsync_fall = ~cam_vsync & r_vsync_q;
    assign w_href_fall  = r_href_q & ~cam_href;
    assign w_start      = (r_state == S_IDLE) & w_grab_rise;

    // Only samples inside the output window count; extra lines/columns fall out here.
    assign w_sample  = grab_enable && (r_state == S_CAPTURE) && cam_href && cam_vsync
                       && (r_col < COL_LIM) && (r_row < ROW_LIM);
    // The R sample of an odd line completes a cell, so the word is pushed then.
    assign w_push    = w_sample & r_row[0] & ~r_col[0];

    // A write stays outstanding from its pop until mem_pause is seen low after the strobe.
    assign w_write_side = grab_enable && ((r_state == S_CAPTURE) || (r_state == S_DRAIN));
    assign w_pop_ok     = ~r_busy | (~r_mem_wren & ~mem_pause);
    assign w_pop        = w_write_side && (r_count != '0) && w_pop_ok;
    assign w_full       = (r_count == DEPTH_C);
    assign w_push_ok    = w_push & (~w_full | w_pop);
    assign w_drop       = w_push & w_full & ~w_pop;

    // Next-state logic; dropping grab_enable returns to IDLE from anywhere.
    always_comb begin
        w_next = r_state;
        if (!grab_enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_grab_rise) w_next = S_ARM;
                S_ARM:     if (w_vsync_rise) w_next = S_CAPTURE;
                S_CAPTURE: if ((r_row == ROW_LIM) || w_vsync_fall) w_next = S_DRAIN;
                S_DRAIN:   if ((r_count == '0) && !r_busy) w_next = S_DONE;
                S_DONE:    w_next = S_DONE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Capture counters, sums, FIFO pointers and the write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grab_q   <= 1'b0;
            r_vsync_q  <= 1'b0;
            r_href_q   <= 1'b0;
            r_base     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_wren <= 1'b0;
            r_words    <= '0;
            r_overflow <= 1'b0;
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
        end else begin
            r_grab_q  <= grab_enable;
            r_vsync_q <= cam_vsync;
            r_href_q  <= cam_href;

            if (r_state != S_CAPTURE) begin
                r_col <= '0;
                r_row <= '0;
            end else begin
                if (!cam_href)
                    r_col <= '0;
                else if (cam_vsync && (r_col != COL_LIM))
                    r_col <= r_col + 1'b1;
                if (w_href_fall && cam_vsync && (r_row != ROW_LIM))
                    r_row <= r_row + 1'b1;
            end

            if (w_sample) begin
                case ({r_row[0], r_col[0]})
                    2'b00:   r_green <= sat_add(r_green, w_chan);
                    2'b01:   r_blue  <= sat_add(r_blue, w_chan);
                    2'b10:   r_red   <= sat_add(r_red, w_chan);
                    default: ;
                endcase
            end
            if (w_drop) r_overflow <= 1'b1;

            // Outside the write side the FIFO is flushed and any pending write abandoned.
            if (!w_write_side) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_busy   <= 1'b0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
                if (w_pop)                         r_busy <= 1'b1;
                else if (r_busy && !r_mem_wren && !mem_pause) r_busy <= 1'b0;
            end

            r_mem_wren <= w_pop;
            if (w_pop) begin
                r_mem_addr <= r_base + r_words;
                r_mem_data <= r_fifo[r_rd_ptr];
            end
            if (r_mem_wren) r_words <= r_words + 1'b1;

            // Grab start wins over everything above.
            if (w_start) begin
                r_base     <= base_addr;
                r_words    <= '0;
                r_overflow <= 1'b0;
                r_red      <= '0;
                r_green    <= '0;
                r_blue     <= '0;
            end
        end
    end

    // Line buffer and FIFO storage hold data only; their contents never need a reset.
    always_ff @(posedge clk) begin
        if (w_sample && !r_row[0]) begin
            if (r_col[0]) r_line_b[w_idx] <= w_chan;
            else          r_line_g[w_idx] <= w_chan;
        end
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= {r_line_b[w_idx], 8'h00, r_line_g[w_idx], w_chan};
    end

    assign grab_done     = (r_state == S_DONE);
    assign mem_addr      = r_mem_addr;
    assign mem_data      = r_mem_data;
    assign mem_wren      = r_mem_wren;
    assign red_sum       = r_red;
    assign green_sum     = r_green;
    assign blue_sum      = r_blue;
    assign words_written = r_words;
    assign overflow      = r_overflow;

endmodule

// File: doc/camera_capture_v3.md
Name: camera_capture_v3

Overview:
- Parametrised single-clock Bayer capture engine: samples a synchronised sensor stream, decimates each 2x2 Bayer cell (G1,B / R,G2) into one packed RGB word, buffers in an internal FIFO and writes the frame to DDR through the pause-handshaked memory port.
- Sits between the sensor input synchroniser and the DDR arbiter.
- Also accumulates per-channel sums for the AGC/shutter block.

Parameters:
- DATA_WIDTH, 12: sensor sample width; channel value = cam_data[DATA_WIDTH-1 -: 8].
- ADDR_WIDTH, 20: DDR word address width.
- OUT_WIDTH, 320: output pixels per line; 2*OUT_WIDTH sensor samples are used per line.
- OUT_HEIGHT, 240: output lines; 2*OUT_HEIGHT sensor lines are used.
- FIFO_DEPTH, 16: output FIFO entries; power of two, at least 4.
- SUM_WIDTH, 26: per-channel accumulator width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- grab_enable  in  1  level; rising edge starts a frame, low aborts.
- grab_done  out  1  frame complete; held high until grab_enable falls.
- base_addr  in  ADDR_WIDTH  DDR address of pixel 0; sampled at grab start.
- cam_href  in  1  line valid, already synchronous to clk.
- cam_vsync  in  1  frame valid, already synchronous to clk.
- cam_data  in  DATA_WIDTH  sample; valid whenever cam_href=1 and cam_vsync=1.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  32  {B[7:0], 8'h00, G[7:0], R[7:0]}.
- mem_wren  out  1  one-cycle write strobe; 1 = write.
- mem_pause  in  1  memory controller busy.
- red_sum  out  SUM_WIDTH  sum of captured R values.
- green_sum  out  SUM_WIDTH  sum of captured G1 values.
- blue_sum  out  SUM_WIDTH  sum of captured B values.
- words_written  out  ADDR_WIDTH  DDR writes issued this frame.
- overflow  out  1  sticky; at least one pixel was dropped on FIFO full.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; line buffer contents don't-care.
- FSM states:
  - IDLE: wait for a grab_enable rising edge. On the edge, latch base_addr, clear sums, words_written, overflow and FIFO, then go to ARM.
  - ARM: wait for a cam_vsync rising edge (0->1), then go to CAPTURE with col=0, row=0.
  - CAPTURE:
    - col increments on each cycle with href&vsync; col resets to 0 when href=0.
    - row increments on each href falling edge while vsync=1.
    - A sample is used only when col < 2*OUT_WIDTH and row < 2*OUT_HEIGHT.
    - Even row, even col: G to linebuf[col>>1] and green_sum.
    - Even row, odd col: B to linebuf[col>>1] and blue_sum.
    - Odd row, even col: R to red_sum, and {B, 0, G, R} pushed to the FIFO the same cycle.
    - Odd row, odd col (G2): discarded.
    - Leave CAPTURE for DRAIN when row reaches 2*OUT_HEIGHT or vsync falls, whichever comes first.
  - DRAIN: stay until the FIFO is empty and no write is outstanding, then go to DONE.
  - DONE: grab_done=1.
  - grab_enable low in any state: next cycle go to IDLE; grab_done=0; FIFO flushed; mem_wren=0; any pending write is abandoned.
- Write side runs in CAPTURE and DRAIN:
  - When the FIFO is non-empty and no write is outstanding, pop. The next cycle drives mem_wren=1 for exactly one cycle, with mem_addr = base_addr + words_written (modulo 2^ADDR_WIDTH) and mem_data = the popped word.
  - words_written increments on that cycle.
  - From the following cycle, wait while mem_pause=1. The next pop is allowed in the cycle mem_pause=0 is sampled, giving at most one write per 2 cycles.
- FIFO full on push: the pixel is dropped and overflow is set. Its sums still accumulate. words_written then ends below OUT_WIDTH*OUT_HEIGHT.
- Push and pop in the same cycle are legal; level is unchanged.
- Sums saturate at all-ones and do not wrap.
- Row/col counters saturate at their limits.
- Extra sensor lines or columns are ignored.

Test Plan:
- OUT_WIDTH=4, OUT_HEIGHT=2, mem_pause=0, sensor 8x4 with samples equal to index<<4 -> exactly 8 writes at base_addr..base_addr+7; word 0 = {8'h01, 8'h00, 8'h00, 8'h08}; grab_done high after the 8th write.
- Same frame with mem_pause held 1 for 5 cycles after each wren -> same 8 words in order; wren pulses spaced at least 6 cycles apart; no overflow at FIFO_DEPTH=16.
- FIFO_DEPTH=4, mem_pause stuck 1 during CAPTURE -> overflow=1; 4 entries retained; after pause is released, DRAIN writes them; grab_done=1; words_written=5 (1 in flight + 4).
- vsync falls after 2 sensor lines -> only 4 words written; FSM goes DRAIN then DONE; grab_done=1.
- grab_enable dropped mid-CAPTURE -> the next cycle has mem_wren=0, grab_done=0, FSM in IDLE; a new grab restarts at base_addr with sums cleared.
- reset_n asserted mid-write -> all outputs 0 immediately (asynchronous); after release, the FSM is in IDLE with no writes.
